// File: rtl/superscalar_pkg.sv
// superscalar_pkg: opcodes, queue entry type, FSM states and decode helpers
package superscalar_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  typedef enum logic [1:0] {RUN, HOLD, DRAIN} ctl_state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } q_entry_t;
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    return instr[31:26] == OP_RTYPE ? instr[15:11] :
           (instr[31:26] == OP_LW || instr[31:26] inside {[OP_ADDI:OP_LUI]}) ? instr[20:16] : 5'd0;
  endfunction
  function automatic logic is_mem(input logic [31:0] instr);
    return instr[31:26] inside {OP_LW, OP_SW};
  endfunction
  function automatic logic is_ctrl(input logic [31:0] instr);
    return instr[31:26] inside {OP_BEQ, OP_BNE, OP_J, OP_JAL};
  endfunction
endpackage

// File: rtl/issue_pair_check.sv
// issue_pair_check: decides whether instr2 may issue alongside instr1
module issue_pair_check
  import superscalar_pkg::*;
(
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  output logic        pair_ok
);
  logic [4:0] d1, d2;
  assign d1 = dest_reg(instr1);
  assign d2 = dest_reg(instr2);
  assign pair_ok = !(is_mem(instr1) && is_mem(instr2)) && !is_ctrl(instr1) &&
                   (d1 == 5'd0 || (instr2[25:21] != d1 && instr2[20:16] != d1 && d2 != d1));
endmodule

// File: rtl/dual_issue_controller.sv
// dual_issue_controller: in-order fetch queue issuing 0-2 instructions per cycle
module dual_issue_controller
  import superscalar_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int IW     = 32,
  parameter int PCW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               fetchValid,
  input  logic [IW-1:0]            fetchInstr1,
  input  logic [IW-1:0]            fetchInstr2,
  input  logic [PCW-1:0]           fetchPC1,
  input  logic [PCW-1:0]           fetchPC2,
  output logic                     fetchReady,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     issueValid1,
  output logic                     issueValid2,
  output logic [IW-1:0]            issueInstr1,
  output logic [IW-1:0]            issueInstr2,
  output logic [PCW-1:0]           issuePC1,
  output logic [PCW-1:0]           issuePC2,
  output logic [$clog2(QDEPTH):0]  queueCount
);
  localparam int AW = $clog2(QDEPTH);
  typedef logic [AW-1:0] ptr_t;
  ctl_state_t state_q, state_d;
  q_entry_t mem_q [QDEPTH];
  q_entry_t mem_d [QDEPTH];
  q_entry_t iss1_q, iss1_d, iss2_q, iss2_d, cand1, cand2;
  ptr_t head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic v1_q, v1_d, v2_q, v2_d, pair_ok;
  logic [1:0] n_enq, n_deq;
  assign cand1 = mem_q[head_q];
  assign cand2 = mem_q[head_q + ptr_t'(1)];
  issue_pair_check u_chk (.instr1(cand1.instr), .instr2(cand2.instr), .pair_ok(pair_ok));
  assign fetchReady  = count_q <= (AW+1)'(QDEPTH - 2);
  assign issueValid1 = v1_q;
  assign issueValid2 = v2_q;
  assign issueInstr1 = iss1_q.instr;
  assign issueInstr2 = iss2_q.instr;
  assign issuePC1    = iss1_q.pc;
  assign issuePC2    = iss2_q.pc;
  assign queueCount  = count_q;
  always_comb begin
    n_enq = fetchReady && fetchValid[0] ? (fetchValid[1] ? 2'd2 : 2'd1) : 2'd0;
    n_deq = stall || count_q == '0 ? 2'd0 : count_q > (AW+1)'(1) && pair_ok ? 2'd2 : 2'd1;
    state_d = flush ? DRAIN : stall && state_q != DRAIN ? HOLD : RUN;
    mem_d = mem_q;
    if (n_enq != 2'd0) mem_d[tail_q] = '{instr: fetchInstr1, pc: fetchPC1};
    if (n_enq == 2'd2) mem_d[tail_q + ptr_t'(1)] = '{instr: fetchInstr2, pc: fetchPC2};
    head_d  = flush ? '0 : head_q + ptr_t'(n_deq);
    tail_d  = flush ? '0 : tail_q + ptr_t'(n_enq);
    count_d = flush ? '0 : count_q + (AW+1)'(n_enq) - (AW+1)'(n_deq);
    v1_d    = flush ? 1'b0 : stall ? v1_q : n_deq != 2'd0;
    v2_d    = flush ? 1'b0 : stall ? v2_q : n_deq == 2'd2;
    iss1_d  = flush || stall ? iss1_q : n_deq != 2'd0 ? cand1 : '0;
    iss2_d  = flush || stall ? iss2_q : n_deq == 2'd2 ? cand2 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      iss1_q  <= '0;
      iss2_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      iss1_q  <= iss1_d;
      iss2_q  <= iss2_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: doc/dual_issue_controller.md
# dual_issue_controller

Front-end scheduler for the two-slot superscalar pipeline. It buffers fetched instruction pairs in a small in-order queue and decides each cycle whether to issue 0, 1 or 2 instructions into decode slots 1/2. Slot 2 is split off when it cannot legally pair with slot 1. The block obeys the stall and flush outputs of the hazard detection unit, and sits between the fetch stage and the IF/ID pipeline registers.

## Interface
- QDEPTH, 4: instruction queue entries; power of two, at least 4
- IW, 32: instruction width
- PCW, 32: PC width
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- fetchValid  in  2  bit0 = fetchInstr1 valid, bit1 = fetchInstr2 valid; 2'b10 is illegal
- fetchInstr1, fetchInstr2  in  IW  fetched instructions, program order 1 then 2
- fetchPC1, fetchPC2  in  PCW  PCs of the fetched instructions
- fetchReady  out  1  queue has at least 2 free entries; combinational from the count
- stall  in  1  OR of the hazard unit's Stall1 and Stall2
- flush  in  1  OR of the hazard unit's Flush1 and Flush2
- issueValid1, issueValid2  out  1  decode slot valid; registered
- issueInstr1, issueInstr2  out  IW  issued instructions; registered
- issuePC1, issuePC2  out  PCW  issued PCs; registered
- queueCount  out  $clog2(QDEPTH)+1  current occupancy

## Operation
- Enqueue: when fetchReady is high and fetchValid is nonzero, write 1 or 2 entries at the tail in program order.
- Decode fields, MIPS layout: op[31:26], rs[25:21], rt[20:16], rd[15:11].
  - Destination: rd if op==0; rt for loads and ALU-immediate ops; none for stores, branches and jumps.
  - A destination of $0 counts as none.
- Slot 1 issues the queue head whenever the queue is non-empty.
- Slot 2 issues head+1 only if all of the following hold:
  - head+1 exists;
  - its rs and rt differ from slot 1's destination (RAW check);
  - its destination differs from slot 1's destination (WAW check);
  - the slots are not both loads/stores (single data port);
  - slot 1 is not a branch or jump.
- Dequeue count equals the number of slots issued. The pointers wrap modulo QDEPTH.
- Simultaneous enqueue and dequeue in one cycle is allowed. Because fetchReady uses the pre-dequeue count, the queue never overflows.
- FSM, three states:
  - RUN: normal issue.
  - HOLD: entered from RUN when stall is high. Issue registers keep their values, there is no dequeue, and enqueue is still permitted. Returns to RUN the first cycle stall is low.
  - DRAIN: entered from any state when flush is high. Head, tail and count clear, issueValid1/2 clear, and this cycle's fetch is discarded. The next cycle is always RUN, and enqueue is accepted during DRAIN.
- Priority: rst > flush > stall > normal issue.

## Timing
- Reset values:
  - issueValid1/2 = 0;
  - issueInstr1/2 = 0 (NOP);
  - issuePC1/2 = 0;
  - queueCount = 0;
  - fetchReady = 1;
  - FSM = RUN.
- Latency from enqueue to issueValid is 1 cycle: an instruction written at edge N appears on the issue outputs after edge N+1.
- Stall takes effect at the same edge: the issue outputs present at edge N stay unchanged after edge N if stall was high in the preceding cycle.
- After a flush sampled at edge N, issueValid1/2 are 0 after edge N. The earliest valid issue is after edge N+2, for instructions fetched during the DRAIN cycle.
- Full queue: fetchReady = 0 when count > QDEPTH-2. Empty queue: issueValid1/2 = 0 with no hold on fetch.
- If rst is asserted mid-operation, all state returns to reset values at the next edge, and in-flight fetch data is dropped.

## Structure
- Shared package `superscalar_pkg` holds:
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, ALU-immediate ops);
  - the queue-entry struct {instr, pc};
  - function dest_reg().
- One sub-module, `issue_pair_check`, is purely combinational. Its inputs are the two candidate instructions and its output is the pair-legal signal. It is reused by verification as a reference model.
- The queue storage, pointers and FSM stay in the top module.

## Test plan
- Independent pair: enqueue 0x01095020 (add $10,$8,$9) and 0x016C6820 (add $13,$11,$12) at PCs 0x0/0x4. After 1 cycle, both issueValid are 1 with PCs 0x0 and 0x4, and queueCount = 0.
- RAW split: enqueue 0x01095020 then 0x014C5822 (sub $11,$10,$12). Cycle 1 issues slot 1 only (add). Cycle 2 issues sub in slot 1, and issueValid2 = 0.
- Memory pair: enqueue lw 0x8D280000 and lw 0x8D2A0004. The loads issue in two consecutive cycles, each in slot 1.
- Stall: hold stall = 1 for 3 cycles mid-stream. The issue outputs stay frozen, the queue fills to 4, and fetchReady falls to 0. On release, issue resumes in order with no loss or duplication.
- Flush: with 3 entries queued, assert flush together with fetchValid = 2'b11. queueCount = 0 and issueValid = 0 for the flush cycle, and the new fetch is not issued. A fetch in the DRAIN cycle issues one cycle later.
- Wrap-around and reset: stream 20 independent instructions, so the pointers wrap 5 times, and check the PC order. Assert rst mid-stream and check every output returns to its reset value after one edge.
